// File: rtl/adder_arbiter_pkg.sv
// Shared types and default sizing for the round-robin arbitrated adder.
package adder_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between N requesters, the arbiter and the result consumer.
interface adder_arbiter_if
  import adder_arbiter_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N-1:0]       req_ready;
  logic               resp_valid;
  logic [ID_W-1:0]    resp_id;
  logic [WIDTH-1:0]   resp_sum;
  logic               resp_carry;
  logic               resp_ready;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_carry
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_carry
  );

endinterface

// File: rtl/adder_arbiter_adder.sv
// Plain combinational W-bit adder shared by all requesters.
module adder_arbiter_adder #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter granting one requester per cycle access to a shared adder,
// with a one-deep registered result stage under consumer backpressure.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic            clk,
  input logic            rst,
  adder_arbiter_if.slave bus
);

  localparam int              ID_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [ID_W:0]   NUM  = (ID_W + 1)'(N);
  localparam logic [ID_W-1:0] LAST = ID_W'(N - 1);

  state_e           state_q;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  logic             arb_en;
  logic             grant;
  logic [ID_W-1:0]  gnt_idx;
  logic [N-1:0]     ready;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH:0]   add_out;

  // A held result blocks new grants unless the consumer drains it this cycle.
  assign arb_en = !rst && ((state_q == IDLE) || bus.resp_ready);

  always_comb begin
    logic [ID_W:0] cand;
    grant   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (cand >= NUM) cand = cand - NUM;
      if (arb_en && !grant && bus.req_valid[cand[ID_W-1:0]]) begin
        grant   = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (grant) ready[gnt_idx] = 1'b1;
  end

  assign ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
  assign a_sel = bus.req_a[gnt_idx*WIDTH +: WIDTH];
  assign b_sel = bus.req_b[gnt_idx*WIDTH +: WIDTH];

  adder_arbiter_adder #(
    .W(WIDTH + 1)
  ) u_adder (
    .a_i  ({1'b0, a_sel}),
    .b_i  ({1'b0, b_sel}),
    .sum_o(add_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (arb_en) begin
      if (grant) begin
        state_q <= RESP;
        ptr_q   <= ptr_d;
        id_q    <= gnt_idx;
        sum_q   <= add_out[WIDTH-1:0];
        carry_q <= add_out[WIDTH];
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_sum   = sum_q;
  assign bus.resp_carry = carry_q;

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing one adder (2..8).
REQ-002 Parameter WIDTH, default 32, operand and sum width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  N  bit i: requester i presents operands.
REQ-006 req_a  input  N*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  N*WIDTH  operand B, same packing as req_a.
REQ-008 req_ready  output  N  one-hot or zero; bit i high means requester i accepted this cycle.
REQ-009 resp_valid  output  1  result on resp_* is valid.
REQ-010 resp_id  output  $clog2(N)  index of requester owning the result.
REQ-011 resp_sum  output  WIDTH  A+B modulo 2^WIDTH.
REQ-012 resp_carry  output  1  carry-out of A+B (bit WIDTH of the exact sum).
REQ-013 resp_ready  input  1  consumer accepts result when high with resp_valid.

Function
REQ-014 Transfer on requester i occurs in a cycle where req_valid[i] and req_ready[i] are both high; response transfer when resp_valid and resp_ready both high.
REQ-015 FSM states IDLE (no result held) and RESP (result held on resp_*).
REQ-016 Arbitration is enabled in IDLE, or in RESP in a cycle where resp_ready is high; otherwise req_ready is all zero.
REQ-017 When enabled and any req_valid is set, exactly one req_ready bit is asserted, combinationally, chosen by round-robin.
REQ-018 Round-robin: search starts at index ptr and wraps N-1 -> 0; first valid index wins.
REQ-019 On each grant to index g, ptr updates to (g+1) mod N on the next edge; ptr unchanged in cycles without a grant.
REQ-020 Granted operands pass through the adder in the grant cycle; sum, carry and g are registered into resp_sum, resp_carry, resp_id at the edge ending that cycle.
REQ-021 Latency: grant in cycle t -> resp_valid high in cycle t+1.
REQ-022 Transitions: IDLE+grant -> RESP; IDLE no grant -> IDLE; RESP+resp_ready+grant -> RESP (new result); RESP+resp_ready no grant -> IDLE; RESP without resp_ready -> RESP, resp_* held stable.
REQ-023 Throughput: one operation per cycle while resp_ready stays high and requests are pending.
REQ-024 resp_valid is high exactly in state RESP; resp_* values do not change while resp_valid high and resp_ready low.
REQ-025 Requesters drop or change req_valid freely; no request is latched without a grant.
REQ-026 Overflow wraps; carry is reported, never saturated (0xFFFFFFFF + 0x1 -> sum 0x0, carry 1).

Reset
REQ-027 While rst high at a clock edge: state IDLE, ptr 0, resp_valid 0, resp_id 0, resp_sum 0, resp_carry 0.
REQ-028 req_ready is all zero in any cycle with rst high.
REQ-029 Reset mid-operation discards any held result; no response for it is ever issued.
REQ-030 First cycle after reset release: requester 0 has highest priority.

Structure
REQ-031 Shared package holds the state enum (IDLE, RESP) and the default N/WIDTH constants.
REQ-032 Exactly one sub-module: the existing adder, instantiated once with width WIDTH+1 on zero-extended operands; its MSB is resp_carry.
REQ-033 Operand mux, round-robin logic and FSM are local; no further sub-modules.

Verification
REQ-034 Single request: req_valid=0001, A=0x3, B=0xF, resp_ready=1 -> req_ready=0001 same cycle; next cycle resp_valid=1, id=0, sum=0x12, carry=0.
REQ-035 All four valid, resp_ready=1 for 5 cycles after reset -> grants 0,1,2,3,0 in successive cycles; responses follow one cycle later with matching ids.
REQ-036 Backpressure: result held, resp_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0000, resp_* stable; resp_ready=1 -> next grant resumes from ptr.
REQ-037 Overflow: A=0xFFFFFFFF, B=0x00000001 -> sum=0x00000000, carry=1; A=0x80000000, B=0x80000000 -> sum=0x0, carry=1.
REQ-038 Reset mid-operation: assert rst while resp_valid=1 -> next cycle resp_valid=0, all resp_* zero, then request from index 2 only -> granted, id=2.
REQ-039 Sparse: req_valid=0100 then 0001 after grant to 2 -> grant 0 (wrap), ptr becomes 1.
